alu_issue_stage: RTL and testbench

- Execute-issue stage directly upstream of the 64-bit ALU. It takes decoded register and immediate operands plus ALUOp/funct fields from decode.
- Generates the ALU's 4-bit Operation code and selects the a/b operands. Pre-conditions b for subtraction, because the ALU datapath has no carry-in.
- Registers the result behind a valid/ready handshake with a one-entry skid buffer, so a stalled ALU consumer never drops an instruction.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_issue_stage_if.sv | 36 +++
 rtl/alu_control_decode.sv | 39 +++
 rtl/alu_issue_stage.sv | 106 ++++++++++
 tb/tb_alu_issue_stage.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Encodings shared by the ALU and its issue stage: decode's ALUOp field
// and the 4-bit Operation code the ALU datapath consumes.
package alu_pkg;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-to-ALU issue bundle. The master side is decode plus the ALU consumer.
// The slave side is the issue stage.
interface alu_issue_stage_if #(
  parameter int WIDTH = 64
);

  // Both handshakes use valid/ready. A transfer happens on a rising edge where
  // valid & ready are both high. While valid is high and ready is low, the
  // source holds valid and its payload unchanged. Ready may depend on state.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] rs2_data;
  logic [WIDTH-1:0] imm;
  logic             alu_src;
  logic [1:0]       alu_op;
  logic [3:0]       funct;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       Operation;
  logic             illegal;

  modport master (
    output in_valid, rs1_data, rs2_data, imm, alu_src, alu_op, funct, out_ready,
    input  in_ready, out_valid, a, b, Operation, illegal
  );

  modport slave (
    input  in_valid, rs1_data, rs2_data, imm, alu_src, alu_op, funct, out_ready,
    output in_ready, out_valid, a, b, Operation, illegal
  );

endinterface

// File: rtl/alu_control_decode.sv
// Combinational ALU control decode: ALUOp/funct to the Operation code.
// Encodings the ALU cannot execute fall back to ADD and raise illegal.
module alu_control_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [3:0] funct_i,
  output logic [3:0] operation_o,
  output logic       illegal_o
);

  always_comb begin
    operation_o = OP_ADD;
    illegal_o   = 1'b0;
    case (alu_op_i)
      ALUOP_MEM: operation_o = OP_ADD;
      ALUOP_BR:  operation_o = OP_SUB;
      ALUOP_R: begin
        case (funct_i)
          4'b0000: operation_o = OP_ADD;
          4'b1000: operation_o = OP_SUB;
          4'b0111: operation_o = OP_AND;
          4'b0110: operation_o = OP_OR;
          default: illegal_o   = 1'b1;
        endcase
      end
      default: begin
        // I-type has no SUB, so instr[30] (funct[3]) carries no meaning here.
        case (funct_i[2:0])
          3'b000:  operation_o = OP_ADD;
          3'b111:  operation_o = OP_AND;
          3'b110:  operation_o = OP_OR;
          default: illegal_o   = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Execute-issue stage: decodes the ALU control and selects the operands.
// It registers one entry behind a main+skid buffer, so a stalled consumer never drops an entry.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  alu_issue_stage_if.slave   io,
  output logic [1:0]         dbg_state_o
);

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_MAIN  = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             illegal;
  } entry_t;

  logic [1:0]       state_q, state_d;
  entry_t           main_q, main_d, skid_q, skid_d, new_e;
  logic [3:0]       dec_op;
  logic             dec_illegal;
  logic [WIDTH-1:0] b_sel;
  logic             accept, emit;

  alu_control_decode u_decode (
    .alu_op_i    (io.alu_op),
    .funct_i     (io.funct),
    .operation_o (dec_op),
    .illegal_o   (dec_illegal)
  );

  // The ALU has no carry-in. Storing b_sel-1 lets it compute a + ~b == a - b_sel.
  assign b_sel = io.alu_src ? io.imm : io.rs2_data;

  always_comb begin
    new_e.a       = io.rs1_data;
    new_e.b       = (dec_op == OP_SUB) ? (b_sel - {{(WIDTH-1){1'b0}}, 1'b1}) : b_sel;
    new_e.op      = dec_op;
    new_e.illegal = dec_illegal;
  end

  assign io.in_ready  = (state_q != ST_FULL) & ~reset;
  assign io.out_valid = (state_q != ST_EMPTY);
  assign accept       = io.in_valid & io.in_ready & ~flush;
  assign emit         = io.out_valid & io.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = new_e;
          state_d = ST_MAIN;
        end
      end
      ST_MAIN: begin
        if (emit && accept) begin
          main_d = new_e;
        end else if (emit) begin
          state_d = ST_EMPTY;
        end else if (accept) begin
          skid_d  = new_e;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (emit) begin
          main_d  = skid_q;
          state_d = ST_MAIN;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush drops only the valids. The data registers keep their stale contents.
    if (flush) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign io.a         = main_q.a;
  assign io.b         = main_q.b;
  assign io.Operation = main_q.op;
  assign io.illegal   = main_q.illegal;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage. A queue-based FIFO reference model
// predicts the outputs. Directed tasks cover the documented scenarios, and one task drives random traffic.
module tb_alu_issue_stage;

  localparam int W  = 64;
  localparam int EW = 2 * W + 5;

  logic       clk;
  logic       reset;
  logic       flush;
  logic [1:0] dbg_state;

  alu_issue_stage_if #(.WIDTH(W)) bus ();

  alu_issue_stage #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .io          (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected entries held by the stage, oldest first: {a, b, Operation, illegal}
  logic [EW-1:0] exp_q[$];

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] ref_entry();
    logic [3:0]   op;
    logic         ill;
    logic [W-1:0] bsel;
    logic [W-1:0] bval;
    op  = 4'b0010;
    ill = 1'b0;
    if (bus.alu_op == 2'b00) op = 4'b0010;
    else if (bus.alu_op == 2'b01) op = 4'b0110;
    else if (bus.alu_op == 2'b10) begin
      if (bus.funct == 4'b0000) op = 4'b0010;
      else if (bus.funct == 4'b1000) op = 4'b0110;
      else if (bus.funct == 4'b0111) op = 4'b0000;
      else if (bus.funct == 4'b0110) op = 4'b0001;
      else ill = 1'b1;
    end else begin
      if (bus.funct[2:0] == 3'b000) op = 4'b0010;
      else if (bus.funct[2:0] == 3'b111) op = 4'b0000;
      else if (bus.funct[2:0] == 3'b110) op = 4'b0001;
      else ill = 1'b1;
    end
    bsel = bus.alu_src ? bus.imm : bus.rs2_data;
    bval = (op == 4'b0110) ? bsel - 64'd1 : bsel;
    return {bus.rs1_data, bval, op, ill};
  endfunction

  function automatic logic [EW-1:0] obs_entry();
    return {bus.a, bus.b, bus.Operation, bus.illegal};
  endfunction

  // ---------------- driver tasks ----------------
  // Advance one clock. Inputs are set at the falling edge, and the model updates with the DUT.
  task automatic tick();
    bit            rdy;
    bit            acc;
    bit            emt;
    logic [EW-1:0] e;
    rdy = (exp_q.size() < 2) && !reset;
    acc = bus.in_valid && rdy;
    emt = (exp_q.size() > 0) && bus.out_ready;
    e   = ref_entry();
    @(posedge clk);
    if (reset || flush) exp_q.delete();
    else begin
      if (emt) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [1:0] op, input logic [3:0] fn, input bit src,
                       input logic [W-1:0] rs1, input logic [W-1:0] rs2, input logic [W-1:0] im);
    bus.in_valid = v;
    bus.alu_op   = op;
    bus.funct    = fn;
    bus.alu_src  = src;
    bus.rs1_data = rs1;
    bus.rs2_data = rs2;
    bus.imm      = im;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 2'b00, 4'h0, 1'b0, '0, '0, '0);
    tick();
    tick();
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
    end
    checks++;
    if ({bus.out_valid, bus.a, bus.b, bus.Operation, bus.illegal} !== '0) begin
      errors++; $display("FAIL reset_outputs: got v=%b a=%h b=%h op=%b ill=%b want all 0",
                         bus.out_valid, bus.a, bus.b, bus.Operation, bus.illegal);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_single_issue();
    bus.out_ready = 1'b1;
    drive(1'b1, 2'b10, 4'b0000, 1'b0, 64'd5, 64'd7, 64'd99);
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.out_valid, bus.a, bus.b, bus.Operation, bus.illegal} !== {1'b1, 64'd5, 64'd7, 4'b0010, 1'b0}) begin
      errors++; $display("FAIL single_issue: got v=%b a=%0d b=%0d op=%b ill=%b want 1/5/7/0010/0",
                         bus.out_valid, bus.a, bus.b, bus.Operation, bus.illegal);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain: out_valid got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_sub();
    logic [W-1:0] alu;
    bus.out_ready = 1'b1;
    drive(1'b1, 2'b01, 4'b0101, 1'b0, 64'd10, 64'd3, 64'd0);
    tick();
    alu = bus.a + ~bus.b;
    checks++;
    if (bus.Operation !== 4'b0110 || bus.b !== 64'd2 || alu !== 64'd7) begin
      errors++; $display("FAIL sub_precond: got op=%b b=%0d alu=%0d want 0110/2/7", bus.Operation, bus.b, alu);
    end
    drive(1'b1, 2'b01, 4'b0000, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0, 64'd0);
    tick();
    alu = bus.a + ~bus.b;
    checks++;
    if (bus.b !== {W{1'b1}} || alu !== 64'h1234_5678_9ABC_DEF0) begin
      errors++; $display("FAIL sub_zero: got b=%h alu=%h want all-ones/123456789abcdef0", bus.b, alu);
    end
    drain();
  endtask

  task automatic test_itype();
    bus.out_ready = 1'b1;
    drive(1'b1, 2'b11, 4'b1110, 1'b1, 64'd42, 64'h1234, 64'hFF);
    tick();
    checks++;
    if (bus.Operation !== 4'b0001 || bus.b !== 64'hFF || bus.illegal !== 1'b0) begin
      errors++; $display("FAIL itype_or: got op=%b b=%h ill=%b want 0001/ff/0", bus.Operation, bus.b, bus.illegal);
    end
    drain();
  endtask

  task automatic test_illegal();
    bus.out_ready = 1'b1;
    drive(1'b1, 2'b10, 4'b0001, 1'b0, 64'd1, 64'd2, 64'd0);
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.Operation !== 4'b0010 || bus.illegal !== 1'b1 || bus.b !== 64'd2) begin
      errors++; $display("FAIL illegal_enc: got v=%b op=%b ill=%b b=%0d want 1/0010/1/2",
                         bus.out_valid, bus.Operation, bus.illegal, bus.b);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL illegal_flow: out_valid got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [EW-1:0] ex[3];
    logic [EW-1:0] got[$];
    bit            taken;
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b10, 4'b0111, 1'b0, 64'hA1, 64'hF0, 64'd0);
    ex[0] = ref_entry();
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ready_e1: got %b want 1", bus.in_ready);
    end
    drive(1'b1, 2'b00, 4'b0000, 1'b1, 64'hB2, 64'd0, 64'h10);
    ex[1] = ref_entry();
    tick();
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_ready_full: got %b want 0", bus.in_ready);
    end
    drive(1'b1, 2'b10, 4'b1000, 1'b0, 64'hC3, 64'h3, 64'd0);
    ex[2] = ref_entry();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || obs_entry() !== ex[0] || bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_stable[%0d]: got v=%b entry=%h ready=%b want 1/%h/0",
                           i, bus.out_valid, obs_entry(), bus.in_ready, ex[0]);
      end
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) got.push_back(obs_entry());
      taken = bus.in_valid && bus.in_ready;
      tick();
      if (taken) bus.in_valid = 1'b0;
    end
    checks++;
    if (got.size() != 3) begin
      errors++; $display("FAIL bp_count: got %0d entries want 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== ex[i]) begin
          errors++; $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], ex[i]);
        end
      end
    end
  endtask

  task automatic fill_full();
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b00, 4'h0, 1'b0, 64'h11, 64'h22, 64'h0);
    tick();
    drive(1'b1, 2'b01, 4'h0, 1'b0, 64'h33, 64'h44, 64'h0);
    tick();
  endtask

  task automatic test_flush();
    fill_full();
    flush = 1'b1;
    drive(1'b1, 2'b10, 4'b0110, 1'b0, 64'hDEAD, 64'hBEEF, 64'h0);
    tick();
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_state: got v=%b ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL flush_no_emit[%0d]: out_valid got %b want 0", i, bus.out_valid);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    fill_full();
    reset = 1'b1;
    drive(1'b1, 2'b10, 4'b0000, 1'b0, 64'h77, 64'h88, 64'h0);
    tick();
    checks++;
    if ({bus.out_valid, bus.a, bus.b, bus.Operation, bus.illegal} !== '0 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_stall: got v=%b a=%h b=%h op=%b ill=%b ready=%b want all 0",
                         bus.out_valid, bus.a, bus.b, bus.Operation, bus.illegal, bus.in_ready);
    end
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_stall_ready: got %b want 1", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_stall_empty: out_valid got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] r1, r2, im;
    for (int n = 0; n < 400; n++) begin
      r1 = {$urandom(), $urandom()};
      r2 = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom(), $urandom()};
      im = {$urandom(), $urandom()};
      drive($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            $urandom_range(0, 1) == 1, r1, r2, im);
      bus.out_ready = $urandom_range(0, 9) < 6;
      flush = $urandom_range(0, 19) == 0;
      #1;
      checks++;
      if (bus.out_valid !== (exp_q.size() > 0) || bus.in_ready !== (exp_q.size() < 2)) begin
        errors++; $display("FAIL rand_ctrl[%0d]: got v=%b ready=%b want %b/%b", n, bus.out_valid,
                           bus.in_ready, exp_q.size() > 0, exp_q.size() < 2);
      end else if (exp_q.size() > 0) begin
        checks++;
        if (obs_entry() !== exp_q[0]) begin
          errors++; $display("FAIL rand_data[%0d]: got %h want %h", n, obs_entry(), exp_q[0]);
        end
      end
      tick();
    end
    flush = 1'b0;
    drain();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    @(negedge clk);
    test_reset();
    test_single_issue();
    test_sub();
    test_itype();
    test_illegal();
    test_backpressure();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
